uart_rx_dma: RTL and testbench
==============================

# uart_rx_dma

Receive-side DMA stage of the UART. It sits directly downstream of `rx_deserializer` and consumes each received byte. It buffers bytes in a small FIFO and writes them one at a time into memory over a byte-wide master port, filling the range from `dst_start` up to (but excluding) `dst_stop`. Software controls it through a 4-entry register window that mirrors the TX-side register scheme.

## Interface
Parameters:
- `M_WIDTH`, 32, width of bus data and address.
- `RX_FIFO_DEPTH`, 8, depth of the byte FIFO. Power of two. Used only with `UART_RX_FIFO_EN`.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high.
- `rx_data`  in  8  received byte from `rx_deserializer`.
- `rx_valid`  in  1  one-cycle pulse; `rx_data` is valid in that cycle.
- `reg_req`  in  1  register access request.
- `reg_we`  in  1  write enable for the access.
- `reg_select`  in  2  register index.
- `reg_data_in`  in  M_WIDTH  register write data.
- `reg_data_out`  out  M_WIDTH  register read data, registered.
- `reg_ready`  out  1  access complete.
- `mem_req`  out  1  memory write request.
- `mem_we`  out  1  always 1 while `mem_req` is high.
- `mem_addr`  out  M_WIDTH  write address; equals `dst_ptr`.
- `mem_data_out`  out  M_WIDTH  zero-extended byte.
- `mem_width`  out  2  constant `MEM_ACC_8`.
- `mem_ready`  in  1  write accepted.
- `rx_irq`  out  1  level signal, equal to `DONE | OVERRUN`.

## Operation
Register map, selected by `reg_select`:
- 0 CFG:
  - bit0 `RX_EN`, read/write.
  - bit1 `DONE`, read-only; defined as `RX_EN & (dst_ptr == dst_stop) & fifo_empty`.
  - bit2 `OVERRUN`, sticky; cleared by writing 1 to this bit.
  - bit3 `FIFO_EMPTY`, read-only.
- 1 DST_START: read/write. A write also loads `dst_ptr` and flushes the FIFO.
- 2 DST_STOP: read/write.
- 3 DST_PTR: read-only; writes are ignored.

Byte intake:
- A byte is accepted when `rx_valid & RX_EN & (dst_ptr != dst_stop)`.
- An accepted byte is pushed if the FIFO is not full. If the FIFO is full, the byte is dropped and `OVERRUN` is set.
- Bytes arriving while `RX_EN=0`, or while `dst_ptr == dst_stop`, are dropped silently; `OVERRUN` is unchanged.
- The FIFO-full test uses the pre-edge flag. A push and a pop in the same cycle with the FIFO full therefore still drops the byte.

Write FSM (`IDLE`, `WAIT`, `ADV`):
- `IDLE` → `WAIT` when `RX_EN & ~fifo_empty & (dst_ptr != dst_stop)`.
- `WAIT`: `mem_req=1`, with address and data held stable. Moves to `ADV` on the cycle `mem_ready` is sampled high.
- `ADV`: pop the FIFO, set `dst_ptr <= dst_ptr + 1`, return to `IDLE`.
- Clearing `RX_EN` during `WAIT` does not abort the write. The write completes and the state machine then parks in `IDLE`.

Arithmetic:
- `dst_ptr` increments modulo 2^M_WIDTH.
- `dst_start > dst_stop` is legal; the pointer wraps around through zero.
- `dst_start == dst_stop` means an empty range: `DONE` is set immediately when `RX_EN` is set.

## Timing
- Reset values: all outputs 0, `mem_width=MEM_ACC_8`, FSM in `IDLE`, all registers 0, FIFO empty.
- Register access: `reg_ready` and `reg_data_out` are valid one cycle after `reg_req`. Reads return the value sampled before a same-cycle write.
- Memory handshake:
  - `mem_req` rises 1 cycle after a byte is pushed into an empty FIFO.
  - Minimum write cost is 3 cycles per byte (`IDLE` → `WAIT` → `ADV`) when `mem_ready` returns the same cycle it is first seen.
  - End-to-end latency from `rx_valid` to `mem_req` is 2 cycles when the FSM is idle.
- Simultaneous register write and FSM advance in the same cycle:
  - A DST_START write wins over the FSM's `dst_ptr` increment, and the FSM returns to `IDLE`.
  - A write-1-to-clear of `OVERRUN` loses to an overrun set in the same cycle.
- A reset asserted mid-transfer drops `mem_req` on the next edge, and the FIFO contents are lost.

## Configuration
- `UART_RX_FIFO_EN` defined: a `fifo` instance of depth `RX_FIFO_DEPTH` is used.
- Not defined: the FIFO is replaced by a single-byte holding register plus a valid flag.
  - "full" = valid flag set; "empty" = valid flag clear.
  - A second byte arriving before the first is written to memory sets `OVERRUN`.
  - All other behaviour and the register map are identical.

## Structure
- Shared package `uart_pkg`:
  - `MEM_ACC_8`/`16`/`32`.
  - Register indices `CFG_ADDR`, `DST_START_ADDR`, `DST_STOP_ADDR`, `DST_PTR_ADDR`.
  - CFG bit positions `RX_EN_BIT`, `RX_DONE_BIT`, `RX_OVERRUN_BIT`, `RX_EMPTY_BIT`.
  - FSM state encoding.
- One sub-module: the existing `fifo` (`DATA_WIDTH=8`), instantiated only under `UART_RX_FIFO_EN`. The FSM and register file stay inline.

## Test plan
- Set START=0x100, STOP=0x104, `RX_EN=1`; send 0x41..0x44 spaced 20 cycles apart → memory writes 0x41@0x100 .. 0x44@0x103; `DONE=1`; `rx_irq=1`; DST_PTR reads 0x104.
- Hold `mem_ready=0`; send 9 bytes back-to-back → first 8 are buffered, 9th sets `OVERRUN`; release `mem_ready` → exactly 8 writes occur; write CFG=0x5 → `OVERRUN` clears while `RX_EN` stays 1.
- Set START=STOP=0x200, `RX_EN=1` → `DONE=1` immediately; send a byte → no `mem_req`, `OVERRUN=0`.
- Set START=0xFFFFFFFE, STOP=0x1; send 3 bytes → writes at 0xFFFFFFFE, 0xFFFFFFFF, 0x0.
- During `WAIT`, write `RX_EN=0` → `mem_req` is held until `mem_ready`, one write completes, then the FSM idles with the remaining bytes kept in the FIFO.
- Assert `rst` while `mem_req=1` → `mem_req=0` on the next cycle; all registers read 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: memory access widths, the RX DMA register
// indices, CFG bit positions and the RX write FSM state encoding.
package uart_pkg;

    localparam logic [1:0] MEM_ACC_8  = 2'd0;
    localparam logic [1:0] MEM_ACC_16 = 2'd1;
    localparam logic [1:0] MEM_ACC_32 = 2'd2;

    localparam logic [1:0] CFG_ADDR       = 2'd0;
    localparam logic [1:0] DST_START_ADDR = 2'd1;
    localparam logic [1:0] DST_STOP_ADDR  = 2'd2;
    localparam logic [1:0] DST_PTR_ADDR   = 2'd3;

    localparam int RX_EN_BIT      = 0;
    localparam int RX_DONE_BIT    = 1;
    localparam int RX_OVERRUN_BIT = 2;
    localparam int RX_EMPTY_BIT   = 3;

    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_WAIT = 2'd1,
        RX_ADV  = 2'd2
    } rx_state_t;

endpackage

// File: rtl/uart_rx_dma_fifo.sv
// fifo: synchronous first-word-fall-through FIFO used as the RX byte buffer.
// Ports: clk, rst (sync, active-high), flush (drops all contents),
// push/push_data, pop/pop_data (head of queue), empty, full.
// DEPTH must be a power of two, at least 2. Push while full and pop while
// empty are ignored.
module fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  empty,
    output logic                  full
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;

    // Extra pointer bit separates full from empty when the indices match.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop && !empty)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full && !flush)
            mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/uart_rx_dma.sv
// uart_rx_dma: receive-side DMA. Buffers bytes from rx_deserializer and
// writes them one per transfer into memory from dst_start up to (excluding)
// dst_stop, over a byte-wide master port.
// Ports: clk, rst (sync, active-high); rx_data/rx_valid (byte intake);
// reg_req/reg_we/reg_select/reg_data_in/reg_data_out/reg_ready (register
// window: CFG, DST_START, DST_STOP, DST_PTR); mem_req/mem_we/mem_addr/
// mem_data_out/mem_width/mem_ready (memory write port); rx_irq (DONE|OVERRUN).
// Build option: define UART_RX_FIFO_EN to buffer in a fifo of RX_FIFO_DEPTH
// entries; otherwise a single holding register is used.
module uart_rx_dma
    import uart_pkg::*;
#(
    parameter int M_WIDTH       = 32,
    parameter int RX_FIFO_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    input  logic               reg_req,
    input  logic               reg_we,
    input  logic [1:0]         reg_select,
    input  logic [M_WIDTH-1:0] reg_data_in,
    output logic [M_WIDTH-1:0] reg_data_out,
    output logic               reg_ready,
    output logic               mem_req,
    output logic               mem_we,
    output logic [M_WIDTH-1:0] mem_addr,
    output logic [M_WIDTH-1:0] mem_data_out,
    output logic [1:0]         mem_width,
    input  logic               mem_ready,
    output logic               rx_irq
);
    if (RX_FIFO_DEPTH < 2 || (RX_FIFO_DEPTH & (RX_FIFO_DEPTH - 1)) != 0)
        $error("RX_FIFO_DEPTH must be a power of two >= 2");

    rx_state_t          state;
    logic               rx_en;
    logic               overrun;
    logic [M_WIDTH-1:0] dst_start;
    logic [M_WIDTH-1:0] dst_stop;
    logic [M_WIDTH-1:0] dst_ptr;

    logic               fifo_empty;
    logic               fifo_full;
    logic [7:0]         fifo_head;

    logic               at_stop;
    logic               accept;
    logic               push;
    logic               pop;
    logic               overrun_set;
    logic               reg_wr;
    logic               cfg_wr;
    logic               start_wr;
    logic               stop_wr;
    logic               done;
    logic [M_WIDTH-1:0] cfg_value;
    logic [M_WIDTH-1:0] rd_value;

    assign at_stop     = (dst_ptr == dst_stop);
    assign accept      = rx_valid & rx_en & ~at_stop;
    // Full is the pre-edge flag, so a same-cycle pop never makes room.
    assign push        = accept & ~fifo_full;
    assign overrun_set = accept & fifo_full;
    assign reg_wr      = reg_req & reg_we;
    assign cfg_wr      = reg_wr & (reg_select == CFG_ADDR);
    assign start_wr    = reg_wr & (reg_select == DST_START_ADDR);
    assign stop_wr     = reg_wr & (reg_select == DST_STOP_ADDR);
    assign pop         = (state == RX_ADV) & ~start_wr;
    assign done        = rx_en & at_stop & fifo_empty;

`ifdef UART_RX_FIFO_EN
    fifo #(
        .DATA_WIDTH (8),
        .DEPTH      (RX_FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (start_wr),
        .push      (push),
        .push_data (rx_data),
        .pop       (pop),
        .pop_data  (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );
`else
    logic       hold_valid;
    logic [7:0] hold_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid <= 1'b0;
            hold_data  <= 8'h00;
        end else if (start_wr) begin
            hold_valid <= 1'b0;
        end else begin
            if (pop)
                hold_valid <= 1'b0;
            if (push) begin
                hold_valid <= 1'b1;
                hold_data  <= rx_data;
            end
        end
    end

    assign fifo_empty = ~hold_valid;
    assign fifo_full  = hold_valid;
    assign fifo_head  = hold_data;
`endif

    always_comb begin
        cfg_value                 = '0;
        cfg_value[RX_EN_BIT]      = rx_en;
        cfg_value[RX_DONE_BIT]    = done;
        cfg_value[RX_OVERRUN_BIT] = overrun;
        cfg_value[RX_EMPTY_BIT]   = fifo_empty;
    end

    always_comb begin
        rd_value = '0;
        case (reg_select)
            CFG_ADDR:       rd_value = cfg_value;
            DST_START_ADDR: rd_value = dst_start;
            DST_STOP_ADDR:  rd_value = dst_stop;
            DST_PTR_ADDR:   rd_value = dst_ptr;
            default:        rd_value = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RX_IDLE;
            mem_req      <= 1'b0;
            rx_en        <= 1'b0;
            overrun      <= 1'b0;
            dst_start    <= '0;
            dst_stop     <= '0;
            dst_ptr      <= '0;
            reg_ready    <= 1'b0;
            reg_data_out <= '0;
        end else begin
            reg_ready <= reg_req;
            if (reg_req)
                reg_data_out <= rd_value;

            if (cfg_wr)
                rx_en <= reg_data_in[RX_EN_BIT];
            // A new overrun outranks a same-cycle write-1-to-clear.
            if (overrun_set)
                overrun <= 1'b1;
            else if (cfg_wr && reg_data_in[RX_OVERRUN_BIT])
                overrun <= 1'b0;
            if (stop_wr)
                dst_stop <= reg_data_in;

            case (state)
                RX_IDLE: begin
                    if (rx_en && !fifo_empty && !at_stop) begin
                        state   <= RX_WAIT;
                        mem_req <= 1'b1;
                    end
                end
                // RX_EN is deliberately not checked here: a started write finishes.
                RX_WAIT: begin
                    if (mem_ready) begin
                        state   <= RX_ADV;
                        mem_req <= 1'b0;
                    end
                end
                RX_ADV: begin
                    dst_ptr <= dst_ptr + M_WIDTH'(1);
                    state   <= RX_IDLE;
                end
                default: begin
                    state   <= RX_IDLE;
                    mem_req <= 1'b0;
                end
            endcase

            // Reprogramming the start address restarts the channel and
            // overrides any pointer advance or transfer in flight.
            if (start_wr) begin
                dst_start <= reg_data_in;
                dst_ptr   <= reg_data_in;
                state     <= RX_IDLE;
                mem_req   <= 1'b0;
            end
        end
    end

    assign mem_we       = mem_req;
    assign mem_addr     = dst_ptr;
    assign mem_data_out = fifo_empty ? '0 : {{(M_WIDTH-8){1'b0}}, fifo_head};
    assign mem_width    = MEM_ACC_8;
    assign rx_irq       = done | overrun;

endmodule

// File: tb/tb_uart_rx_dma.sv
module tb_uart_rx_dma;
    import uart_pkg::*;

`ifdef UART_RX_FIFO_EN
    localparam int MODEL_CAP = 8;
`else
    localparam int MODEL_CAP = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        reg_req;
    logic        reg_we;
    logic [1:0]  reg_select;
    logic [31:0] reg_data_in;
    logic [31:0] reg_data_out;
    logic        reg_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_data_out;
    logic [1:0]  mem_width;
    logic        mem_ready;
    logic        rx_irq;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        we;
        logic [1:0]  width;
    } wr_t;

    wr_t wq[$];
    int  req_cycles;

    uart_rx_dma #(.M_WIDTH(32), .RX_FIFO_DEPTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .reg_req      (reg_req),
        .reg_we       (reg_we),
        .reg_select   (reg_select),
        .reg_data_in  (reg_data_in),
        .reg_data_out (reg_data_out),
        .reg_ready    (reg_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_data_out (mem_data_out),
        .mem_width    (mem_width),
        .mem_ready    (mem_ready),
        .rx_irq       (rx_irq)
    );

    always #5 clk = ~clk;

    // Memory-side observer: a write is accepted on an edge where both
    // mem_req and mem_ready are high.
    always @(posedge clk) begin
        if (!rst && mem_req) begin
            req_cycles <= req_cycles + 1;
            if (mem_ready)
                wq.push_back('{addr: mem_addr, data: mem_data_out, we: mem_we, width: mem_width});
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic reg_write(input logic [1:0] sel, input logic [31:0] d);
        reg_req = 1'b1; reg_we = 1'b1; reg_select = sel; reg_data_in = d;
        tick();
        reg_req = 1'b0; reg_we = 1'b0;
    endtask

    task automatic reg_read(input logic [1:0] sel, output logic [31:0] d);
        reg_req = 1'b1; reg_we = 1'b0; reg_select = sel;
        tick();
        d = reg_data_out;
        reg_req = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic wait_writes(input string tag, input int n, input int budget);
        int cnt = 0;
        while (wq.size() < n && cnt < budget) begin
            tick();
            cnt++;
        end
        tick(8);
        check(tag, wq.size(), n);
    endtask

    task automatic expect_write(input string tag, input logic [31:0] a, input logic [7:0] b);
        wr_t w;
        if (wq.size() == 0) begin
            check({tag, "_present"}, 0, 1);
        end else begin
            w = wq.pop_front();
            check({tag, "_addr"}, w.addr, a);
            check({tag, "_data"}, w.data, {24'h0, b});
            check({tag, "_we"}, {31'h0, w.we}, 1);
            check({tag, "_width"}, {30'h0, w.width}, {30'h0, MEM_ACC_8});
        end
    endtask

    task automatic setup_range(input logic [31:0] start, input logic [31:0] stop);
        reg_write(DST_START_ADDR, start);
        reg_write(DST_STOP_ADDR, stop);
    endtask

    initial begin
        logic [31:0] rd;
        logic [7:0]  bytes[$];
        int          k;

        rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; reg_req = 1'b0; reg_we = 1'b0;
        reg_select = 2'd0; reg_data_in = 32'h0; mem_ready = 1'b1; req_cycles = 0;
        tick(3);
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_mem_req", {31'h0, mem_req}, 0);
        check("rst_mem_width", {30'h0, mem_width}, {30'h0, MEM_ACC_8});
        check("rst_irq", {31'h0, rx_irq}, 0);
        reg_read(CFG_ADDR, rd);       check("rst_cfg", rd, 32'h8);
        check("rst_reg_ready", {31'h0, reg_ready}, 1);
        reg_read(DST_START_ADDR, rd); check("rst_start", rd, 0);
        reg_read(DST_PTR_ADDR, rd);   check("rst_ptr", rd, 0);

        // Basic transfer with latency check on the first byte
        setup_range(32'h100, 32'h104);
        reg_write(CFG_ADDR, 32'h1);
        send_byte(8'h41);
        check("lat_push_edge", {31'h0, mem_req}, 0);
        tick();
        check("lat_2cyc", {31'h0, mem_req}, 1);
        tick(18);
        for (int i = 1; i < 4; i++) begin
            send_byte(8'h41 + 8'(i));
            tick(19);
        end
        wait_writes("basic_count", 4, 50);
        for (int i = 0; i < 4; i++)
            expect_write("basic", 32'h100 + 32'(i), 8'h41 + 8'(i));
        reg_read(CFG_ADDR, rd);     check("basic_cfg_done", rd, 32'hB);
        check("basic_irq", {31'h0, rx_irq}, 1);
        reg_read(DST_PTR_ADDR, rd); check("basic_ptr", rd, 32'h104);

        // Overrun with a stalled memory
        mem_ready = 1'b0;
        setup_range(32'h300, 32'h320);
        bytes.delete();
        for (int i = 0; i < 9; i++) begin
            bytes.push_back(8'($urandom_range(0, 255)));
            rx_data = bytes[i]; rx_valid = 1'b1;
            tick();
        end
        rx_valid = 1'b0;
        tick(4);
        reg_read(CFG_ADDR, rd);
        check("ovr_set", {31'h0, rd[RX_OVERRUN_BIT]}, 1);
        check("ovr_irq", {31'h0, rx_irq}, 1);
        check("ovr_stalled_req", {31'h0, mem_req}, 1);
        check("ovr_no_writes", wq.size(), 0);
        mem_ready = 1'b1;
        wait_writes("ovr_count", MODEL_CAP, 100);
        for (int i = 0; i < MODEL_CAP; i++)
            expect_write("ovr", 32'h300 + 32'(i), bytes[i]);
        reg_write(CFG_ADDR, 32'h5);
        reg_read(CFG_ADDR, rd);     check("ovr_clear", rd, 32'h9);

        // Empty range
        setup_range(32'h200, 32'h200);
        reg_read(CFG_ADDR, rd);     check("empty_done", rd, 32'hB);
        req_cycles = 0;
        send_byte(8'h5A);
        tick(10);
        check("empty_no_req", req_cycles, 0);
        check("empty_no_write", wq.size(), 0);
        reg_read(CFG_ADDR, rd);     check("empty_no_ovr", rd, 32'hB);

        // Wrap through zero
        setup_range(32'hFFFF_FFFE, 32'h1);
        for (int i = 0; i < 3; i++) begin
            send_byte(8'hA0 + 8'(i));
            tick(9);
        end
        wait_writes("wrap_count", 3, 50);
        expect_write("wrap0", 32'hFFFF_FFFE, 8'hA0);
        expect_write("wrap1", 32'hFFFF_FFFF, 8'hA1);
        expect_write("wrap2", 32'h0000_0000, 8'hA2);

        // Disable during WAIT
        k = (MODEL_CAP >= 2) ? 2 : 1;
        mem_ready = 1'b0;
        setup_range(32'h400, 32'h410);
        for (int i = 0; i < k; i++)
            send_byte(8'hC0 + 8'(i));
        tick(2);
        reg_write(CFG_ADDR, 32'h0);
        tick(3);
        check("dis_req_held", {31'h0, mem_req}, 1);
        mem_ready = 1'b1;
        wait_writes("dis_count", 1, 20);
        expect_write("dis", 32'h400, 8'hC0);
        check("dis_idle", {31'h0, mem_req}, 0);
        reg_read(CFG_ADDR, rd);     check("dis_cfg", rd, (k == 1) ? 32'h8 : 32'h0);
        reg_read(DST_PTR_ADDR, rd); check("dis_ptr", rd, 32'h401);

        // Randomized ranges against the address/byte model
        for (int r = 0; r < 6; r++) begin
            logic [31:0] start;
            int len, n, m;
            start = $urandom();
            if (r == 0) start = 32'hFFFF_FFFD;
            len = $urandom_range(1, 6);
            n   = $urandom_range(1, 8);
            m   = (n < len) ? n : len;
            setup_range(start, start + 32'(len));
            reg_write(CFG_ADDR, 32'h5);
            bytes.delete();
            for (int i = 0; i < n; i++) begin
                bytes.push_back(8'($urandom_range(0, 255)));
                send_byte(bytes[i]);
                tick($urandom_range(6, 12));
            end
            wait_writes($sformatf("rnd%0d_count", r), m, 50);
            for (int i = 0; i < m; i++)
                expect_write($sformatf("rnd%0d_%0d", r, i), start + 32'(i), bytes[i]);
            reg_read(DST_PTR_ADDR, rd); check($sformatf("rnd%0d_ptr", r), rd, start + 32'(m));
            reg_read(CFG_ADDR, rd);
            check($sformatf("rnd%0d_ovr", r), {31'h0, rd[RX_OVERRUN_BIT]}, 0);
            check($sformatf("rnd%0d_done", r), {31'h0, rd[RX_DONE_BIT]}, (n >= len) ? 1 : 0);
        end

        // Reset mid-transfer
        setup_range(32'h500, 32'h510);
        reg_write(CFG_ADDR, 32'h1);
        mem_ready = 1'b0;
        send_byte(8'h77);
        k = 0;
        while (!mem_req && k < 10) begin
            tick();
            k++;
        end
        check("rstx_req_before", {31'h0, mem_req}, 1);
        rst = 1'b1;
        tick();
        check("rstx_req_drop", {31'h0, mem_req}, 0);
        rst = 1'b0;
        mem_ready = 1'b1;
        reg_read(CFG_ADDR, rd);       check("rstx_cfg", rd, 32'h8);
        reg_read(DST_START_ADDR, rd); check("rstx_start", rd, 0);
        reg_read(DST_STOP_ADDR, rd);  check("rstx_stop", rd, 0);
        reg_read(DST_PTR_ADDR, rd);   check("rstx_ptr", rd, 0);
        tick(5);
        check("rstx_no_write", wq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
